// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID register. Handles stall, branch redirect and a trap-driven halt.
module if_stage #(
  parameter logic [0:31] RESET_PC  = 32'h00000000,
  parameter logic [0:31] NOP_WORD  = 32'h00000000,
  parameter logic [0:31] TRAP_WORD = 32'h44000300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [0:31] branch_target,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_data,
  output logic [0:31] instruction_0,
  output logic [0:31] pc_plus4_0,
  output logic        valid_0,
  output logic        halted,
  output logic [0:31] fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  // PC is kept as a word index so the two byte-offset bits are zero by construction.
  logic [0:29] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [0:31] count_q, count_d;
  logic [0:29] pc_next_word;

  assign pc_next_word = pc_q + 30'd1;

  // NOTE: every signal written here gets its hold value first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (branch) begin
      // A redirect squashes whatever was fetched, including a wrong-path trap.
      state_d = RUN;
      pc_d    = branch_target[0:29];
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (state_q == RUN && !stall) begin
      pc_d    = pc_next_word;
      instr_d = imem_data;
      pc4_d   = {pc_next_word, 2'b00};
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
      if (imem_data == TRAP_WORD) state_d = HALT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC[0:29];
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h00000000;
      valid_q <= 1'b0;
      count_q <= 32'h00000000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr     = {pc_q, 2'b00};
  assign instruction_0 = instr_q;
  assign pc_plus4_0    = pc4_q;
  assign valid_0       = valid_q;
  assign halted        = (state_q == HALT);
  assign fetch_count   = count_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, the word injected into IF/ID on flush.
REQ-003 SHALL have parameter TRAP_WORD, default 32'h44000300, the end-of-program trap encoding.
REQ-004 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  decode-stage load-use stall; holds PC and IF/ID.
REQ-007 SHALL have port branch  input  1  taken branch or jump resolved downstream; redirects fetch.
REQ-008 SHALL have port branch_target  input  [0:31]  redirect address, big-endian bit order.
REQ-009 SHALL have port imem_addr  output  [0:31]  instruction memory byte address, combinational from PC.
REQ-010 SHALL have port imem_data  input  [0:31]  instruction word returned combinationally for imem_addr.
REQ-011 SHALL have port instruction_0  output  [0:31]  IF/ID instruction register.
REQ-012 SHALL have port pc_plus4_0  output  [0:31]  IF/ID link value, the fetching PC + 4.
REQ-013 SHALL have port valid_0  output  1  IF/ID holds a real fetched instruction and not a bubble.
REQ-014 SHALL have port halted  output  1  the trap has been fetched and fetch is frozen.
REQ-015 SHALL have port fetch_count  output  [0:31]  number of instructions latched with valid_0=1 since reset.

Function
REQ-016 SHALL drive imem_addr = PC, with bits [30:31] of PC always zero.
REQ-017 SHALL apply per-edge priority: reset > branch > halted > stall > normal fetch.
REQ-018 Normal fetch: PC <= PC+4; instruction_0 <= imem_data; pc_plus4_0 <= PC+4; valid_0 <= 1; fetch_count += 1.
REQ-019 Stall without branch: PC, instruction_0, pc_plus4_0, valid_0 and fetch_count all held.
REQ-020 Branch: PC <= {branch_target[0:29], 2'b00}; instruction_0 <= NOP_WORD; valid_0 <= 0; pc_plus4_0 held; fetch_count held.
REQ-021 Branch SHALL take effect even when stall=1 or halted=1 in the same cycle, and clears halted (the trap was wrong-path).
REQ-022 Trap: on a normal fetch where imem_data == TRAP_WORD, the trap SHALL be latched as in REQ-018 and halted set to 1 on that edge.
REQ-023 While halted=1 and branch=0: PC frozen at trap address + 4; IF/ID holds the trap with valid_0=1; fetch_count frozen.
REQ-024 A trap word arriving while stall=1 SHALL NOT set halted until it is actually latched.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000) without any flag.
REQ-026 fetch_count SHALL wrap modulo 2^32.
REQ-027 States: RUN (halted=0) and HALT (halted=1). RUN->HALT per REQ-022. HALT->RUN only on branch or reset.

Reset
REQ-028 On reset=1 at an edge: PC <= RESET_PC; instruction_0 <= NOP_WORD; pc_plus4_0 <= 0; valid_0 <= 0; halted <= 0; fetch_count <= 0.
REQ-029 Reset SHALL override stall, branch and trap in the same cycle.
REQ-030 Reset asserted mid-halt or mid-stall SHALL return the block to RUN with outputs as in REQ-028 on the next edge.
REQ-031 imem_addr SHALL equal RESET_PC in the first cycle after reset deasserts.

Verification
REQ-032 Sequential fetch: reset, IMEM words 0x20010005, 0x20020007, stall=0 -> imem_addr 0,4,8; instruction_0 0x20010005 then 0x20020007; fetch_count 1, 2.
REQ-033 Stall: stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, instruction_0 unchanged, fetch_count unchanged; resumes at 12 when stall drops.
REQ-034 Branch with stall: branch=1, stall=1, branch_target=0x00000043 -> next imem_addr 0x40, instruction_0=NOP_WORD, valid_0=0.
REQ-035 Trap: word 0x44000300 at address 0x10 -> instruction_0=0x44000300, halted=1, imem_addr frozen at 0x14 for 10 cycles.
REQ-036 Squashed trap: trap fetched and branch=1 on the following edge to 0x80 -> halted=0, imem_addr=0x80, fetch continues.
REQ-037 Wrap and reset: branch to 0xFFFFFFFC, then one fetch -> imem_addr 0x00000000. Reset asserted while halted -> all outputs match REQ-028 after one edge.
